// File: rtl/ebr_sdp_pkg.sv
// ebr_sdp_pkg: shared types and elaboration helpers for ebr_sdp_ram.
// Clear-sequencer state enum, clog2, config check, aspect-ratio lane helpers.
package ebr_sdp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit width_ok(input int w);
    return (w == 2) || (w == 4) || (w == 8) || (w == 16);
  endfunction

  // The read side needs at least two words so RADDR_W is non-zero.
  function automatic bit cfg_ok(
    input int ww,
    input int rw,
    input int depth
  );
    return width_ok(ww) && width_ok(rw) &&
           is_pow2(depth) && (depth >= 2) &&
           ((depth * ww / rw) >= 2);
  endfunction

  // Lane within a wide word for a narrow-side address.
  function automatic int slice_idx(input int addr, input int lr);
    return addr & ((1 << lr) - 1);
  endfunction

  // Wide-word index for a narrow-side address.
  function automatic int word_idx(input int addr, input int lr);
    return addr >> lr;
  endfunction

endpackage

// File: rtl/ebr_sdp_clr_seq.sv
// ebr_sdp_clr_seq: clear sweep FSM and write-port mux into the storage.
// In: clk, resetn, clr_req, we/waddr/wdata/wmask. Out: m_* write bundle, clr_busy.
module ebr_sdp_clr_seq
  import ebr_sdp_pkg::*;
#(
  parameter int WDATA_W  = 16,
  parameter int WADDR_W  = 8,
  parameter int WR_DEPTH = 256
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clr_req,
  input  logic               we,
  input  logic [WADDR_W-1:0] waddr,
  input  logic [WDATA_W-1:0] wdata,
  input  logic [WDATA_W-1:0] wmask,
  output logic               m_we,
  output logic [WADDR_W-1:0] m_waddr,
  output logic [WDATA_W-1:0] m_wdata,
  output logic [WDATA_W-1:0] m_wmask,
  output logic               clr_busy
);

  localparam logic [WADDR_W-1:0] LAST =
    WADDR_W'(WR_DEPTH - 1);

  clr_state_t         state, state_n;
  logic [WADDR_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_n = cnt + WADDR_W'(1);
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  always_comb begin
    clr_busy = 1'b0;
    m_we     = we;
    m_waddr  = waddr;
    m_wdata  = wdata;
    m_wmask  = wmask;
    unique case (state)
      CLEAR: begin
        clr_busy = 1'b1;
        m_we     = 1'b1;
        m_waddr  = cnt;
        m_wdata  = '0;
        m_wmask  = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ebr_sdp_ram.sv
// ebr_sdp_ram: SDP block RAM, mixed aspect, bit mask, registered read, clear sweep.
// Ports: clk, resetn, we/waddr/wdata/wmask, re/raddr, rdata/rvalid, clr_req/clr_busy. Option: EBR_SDP_OUTREG_EN.
module ebr_sdp_ram
  import ebr_sdp_pkg::*;
#(
  parameter int WDATA_W  = 16,
  parameter int RDATA_W  = 16,
  parameter int WR_DEPTH = 256,
  localparam int RD_DEPTH = WR_DEPTH * WDATA_W / RDATA_W,
  localparam int WADDR_W  = clog2(WR_DEPTH),
  localparam int RADDR_W  = clog2(RD_DEPTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               we,
  input  logic [WADDR_W-1:0] waddr,
  input  logic [WDATA_W-1:0] wdata,
  input  logic [WDATA_W-1:0] wmask,
  input  logic               re,
  input  logic [RADDR_W-1:0] raddr,
  output logic [RDATA_W-1:0] rdata,
  output logic               rvalid,
  input  logic               clr_req,
  output logic               clr_busy
);

  if (!cfg_ok(WDATA_W, RDATA_W, WR_DEPTH)) begin : g_bad_cfg
    $error("ebr_sdp_ram: illegal WDATA_W/RDATA_W/WR_DEPTH");
  end

  localparam int MEM_W = (WDATA_W > RDATA_W) ? WDATA_W : RDATA_W;
  localparam int MIN_W = (WDATA_W > RDATA_W) ? RDATA_W : WDATA_W;
  localparam int R     = MEM_W / MIN_W;
  localparam int LR    = clog2(R);
  // Only the narrow side carries lane bits in its address.
  localparam int WLR   = (WDATA_W < RDATA_W) ? LR : 0;
  localparam int RLR   = (RDATA_W < WDATA_W) ? LR : 0;
  localparam int MEM_D = WR_DEPTH * WDATA_W / MEM_W;
  localparam int MA_W  = clog2(MEM_D);

  logic               m_we;
  logic [WADDR_W-1:0] m_waddr;
  logic [WDATA_W-1:0] m_wdata;
  logic [WDATA_W-1:0] m_wmask;

  ebr_sdp_clr_seq #(
    .WDATA_W  (WDATA_W),
    .WADDR_W  (WADDR_W),
    .WR_DEPTH (WR_DEPTH)
  ) u_clr (
    .clk      (clk),
    .resetn   (resetn),
    .clr_req  (clr_req),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wmask    (wmask),
    .m_we     (m_we),
    .m_waddr  (m_waddr),
    .m_wdata  (m_wdata),
    .m_wmask  (m_wmask),
    .clr_busy (clr_busy)
  );

  logic [MEM_W-1:0]   mem [MEM_D];
  logic [MA_W-1:0]    widx, ridx;
  logic [MEM_W-1:0]   wr_bits, wr_keep, rword;
  logic [RDATA_W-1:0] rd_slice;
  logic               rd_en;

  // Expand the narrow write into a full-width word plus keep mask.
  always_comb begin
    widx    = MA_W'(word_idx(int'(m_waddr), WLR));
    wr_bits = '0;
    wr_keep = '1;
    for (int j = 0; j < (1 << WLR); j++) begin
      if (slice_idx(int'(m_waddr), WLR) == j) begin
        wr_bits[j*WDATA_W +: WDATA_W] = m_wdata;
        wr_keep[j*WDATA_W +: WDATA_W] = m_wmask;
      end
    end
  end

  always_comb begin
    ridx     = MA_W'(word_idx(int'(raddr), RLR));
    rword    = mem[ridx];
    rd_slice = '0;
    for (int j = 0; j < (1 << RLR); j++) begin
      if (slice_idx(int'(raddr), RLR) == j)
        rd_slice = rword[j*RDATA_W +: RDATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (m_we)
      mem[widx] <= (mem[widx] & wr_keep) |
                   (wr_bits & ~wr_keep);
  end

  assign rd_en = re & ~clr_busy;

  logic [RDATA_W-1:0] rdata_q;
  logic               rvalid_q;

  // Sampling mem before the same-edge write gives read-before-write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rd_slice;
    end
  end

`ifdef EBR_SDP_OUTREG_EN
  logic [RDATA_W-1:0] rdata_p;
  logic               rvalid_p;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_p  <= '0;
      rvalid_p <= 1'b0;
    end else begin
      rvalid_p <= rvalid_q;
      if (rvalid_q) rdata_p <= rdata_q;
    end
  end

  assign rdata  = rdata_p;
  assign rvalid = rvalid_p;
`else
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_ebr_sdp_ram.sv
// tb_ebr_sdp_ram: directed vectors for ebr_sdp_ram (16/16 and 16/4 builds).
// Covers clear timing, masking, aspect ratio, collisions, drops, reset mid-sweep.
module tb_ebr_sdp_ram;

`ifdef EBR_SDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        we, re, clr_req;
  logic [7:0]  waddr, raddr;
  logic [15:0] wdata, wmask, rdata;
  logic        rvalid, clr_busy;

  logic        we2, re2, clr_req2;
  logic [7:0]  waddr2;
  logic [9:0]  raddr2;
  logic [15:0] wdata2, wmask2;
  logic [3:0]  rdata2;
  logic        rvalid2, clr_busy2;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_rd;

  ebr_sdp_ram dut (
    .clk      (clk),
    .resetn   (resetn),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wmask    (wmask),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  ebr_sdp_ram #(
    .WDATA_W  (16),
    .RDATA_W  (4),
    .WR_DEPTH (256)
  ) dut2 (
    .clk      (clk),
    .resetn   (resetn),
    .we       (we2),
    .waddr    (waddr2),
    .wdata    (wdata2),
    .wmask    (wmask2),
    .re       (re2),
    .raddr    (raddr2),
    .rdata    (rdata2),
    .rvalid   (rvalid2),
    .clr_req  (clr_req2),
    .clr_busy (clr_busy2)
  );

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] mask;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(
    input logic [7:0]  a,
    input logic [15:0] d,
    input logic [15:0] m
  );
    we = 1'b1; waddr = a; wdata = d; wmask = m;
    step();
    we = 1'b0;
    chk("wr_rvalid_low", {31'b0, rvalid}, 32'd0);
    chk("wr_rdata_hold", {16'b0, rdata}, {16'b0, last_rd});
  endtask

  task automatic rd(
    input string       nm,
    input logic [7:0]  a,
    input logic [15:0] e
  );
    re = 1'b1; raddr = a;
    step();
    re = 1'b0;
    repeat (LAT - 1) step();
    chk({nm, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    chk({nm, "_rdata"}, {16'b0, rdata}, {16'b0, e});
    last_rd = e;
  endtask

  task automatic rd2(
    input logic [9:0] a,
    input logic [3:0] e
  );
    re2 = 1'b1; raddr2 = a;
    step();
    re2 = 1'b0;
    repeat (LAT - 1) step();
    chk($sformatf("n4_rvalid_%0d", a), {31'b0, rvalid2}, 32'd1);
    chk($sformatf("n4_rdata_%0d", a), {28'b0, rdata2}, {28'b0, e});
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (clr_busy && n < 1000) begin
      n++;
      step();
    end
    chk(nm, n, 256);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0;
    we = 0; re = 0; clr_req = 0;
    waddr = 0; raddr = 0; wdata = 0; wmask = 0;
    we2 = 0; re2 = 0; clr_req2 = 0;
    waddr2 = 0; raddr2 = 0; wdata2 = 0; wmask2 = 0;
    last_rd = 16'h0;

    vt[0]  = '{0, 8'h10, 16'h0000, 16'h0000, 16'h0000};
    vt[1]  = '{1, 8'h03, 16'hA5A5, 16'h00FF, 16'h0000};
    vt[2]  = '{0, 8'h03, 16'h0000, 16'h0000, 16'hA500};
    vt[3]  = '{1, 8'h03, 16'hFFFF, 16'hFF00, 16'h0000};
    vt[4]  = '{0, 8'h03, 16'h0000, 16'h0000, 16'hA5FF};
    vt[5]  = '{1, 8'hFF, 16'h1234, 16'h0000, 16'h0000};
    vt[6]  = '{0, 8'hFF, 16'h0000, 16'h0000, 16'h1234};
    vt[7]  = '{1, 8'h00, 16'hCAFE, 16'h0000, 16'h0000};
    vt[8]  = '{0, 8'h00, 16'h0000, 16'h0000, 16'hCAFE};
    vt[9]  = '{1, 8'h00, 16'h0000, 16'hFFFF, 16'h0000};
    vt[10] = '{0, 8'h00, 16'h0000, 16'h0000, 16'hCAFE};
    vt[11] = '{0, 8'h01, 16'h0000, 16'h0000, 16'h0000};
    vt[12] = '{1, 8'h07, 16'h1111, 16'h0000, 16'h0000};
    vt[13] = '{0, 8'h07, 16'h0000, 16'h0000, 16'h1111};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, clr_busy}, 32'd1);
    chk("rst_rdata", {16'b0, rdata}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_busy2", {31'b0, clr_busy2}, 32'd1);
    resetn = 1'b1;
    count_busy("clear_len_reset");
    chk("busy2_done", {31'b0, clr_busy2}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].is_wr)
        wr(vt[i].addr, vt[i].data, vt[i].mask);
      else
        rd($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
    end

    // 16-bit write, 4-bit read: lanes little-endian.
    we2 = 1'b1; waddr2 = 8'd5; wdata2 = 16'h1234; wmask2 = 16'h0;
    step();
    we2 = 1'b0;
    rd2(10'd20, 4'h4);
    rd2(10'd21, 4'h3);
    rd2(10'd22, 4'h2);
    rd2(10'd23, 4'h1);
    rd2(10'd19, 4'h0);

    // Same-cycle write and read of address 7.
    we = 1'b1; waddr = 8'h07; wdata = 16'hBEEF; wmask = 16'h0;
    re = 1'b1; raddr = 8'h07;
    step();
    we = 1'b0; re = 1'b0;
    repeat (LAT - 1) step();
    chk("coll_rvalid", {31'b0, rvalid}, 32'd1);
    chk("coll_old", {16'b0, rdata}, 32'h1111);
    last_rd = 16'h1111;
    rd("coll_new", 8'h07, 16'hBEEF);

    // Clear request; traffic during busy is dropped, re-request ignored.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    we = 1'b1; waddr = 8'h02; wdata = 16'hFFFF; wmask = 16'h0;
    re = 1'b1; raddr = 8'h02;
    n = 0;
    while (clr_busy && n < 1000) begin
      clr_req = (n == 10);
      if (n < 8) begin
        chk("busy_rvalid", {31'b0, rvalid}, 32'd0);
        chk("busy_rdata", {16'b0, rdata}, {16'b0, last_rd});
      end
      if (n == 8) begin
        we = 1'b0; re = 1'b0;
      end
      n++;
      step();
    end
    clr_req = 1'b0; we = 1'b0; re = 1'b0;
    chk("clear_len_req", n, 256);
    rd("clr_a2", 8'h02, 16'h0000);
    rd("clr_a3", 8'h03, 16'h0000);
    rd("clr_a7", 8'h07, 16'h0000);

    // Reset in the middle of a sweep restarts it from zero.
    wr(8'h40, 16'h5A5A, 16'h0000);
    rd("pre_rst", 8'h40, 16'h5A5A);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (100) step();
    chk("mid_busy", {31'b0, clr_busy}, 32'd1);
    resetn = 1'b0;
    #2;
    chk("mid_rst_rdata", {16'b0, rdata}, 32'd0);
    chk("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
    last_rd = 16'h0;
    step();
    step();
    chk("mid_rst_busy", {31'b0, clr_busy}, 32'd1);
    resetn = 1'b1;
    count_busy("clear_len_restart");
    rd("post_rst", 8'h40, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
